// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RISC-V branch comparator.
// Operands are captured on accept, then compared CHUNK bits per cycle,
// MSB slice first. The result is held in DONE until the consumer takes it.
module branch_cmp_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            lt,
    output logic            eq,
    output logic            illegal
);

    localparam int N  = XLEN / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // A partial final slice would silently change the result, so refuse to build.
    if ((XLEN % CHUNK) != 0 || CHUNK <= 0) begin : g_bad_chunk
        $error("branch_cmp_seq: XLEN must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [2:0]      f3_q;
    logic            eq_acc;
    logic            lt_acc;

    logic             accept;
    logic             last;
    logic             signed_cmp;
    logic [XLEN-1:0]  msb_flip;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;

    assign accept     = (state == IDLE) && in_valid && !flush;
    assign last       = (count == CW'(N - 1));
    // BLT/BGE are the only signed codes; flipping the sign bits maps
    // two's-complement order onto unsigned order.
    assign signed_cmp = (funct3[2:1] == 2'b10);
    assign msb_flip   = {signed_cmp, {(XLEN-1){1'b0}}};
    // Operand registers shift left each BUSY cycle, so the current slice
    // always sits at the top.
    assign a_slice    = a_q[XLEN-1 -: CHUNK];
    assign b_slice    = b_q[XLEN-1 -: CHUNK];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every other request
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  state_nxt = BUSY;
                BUSY:    if (last)      state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default:                state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture and per-slice accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            f3_q   <= '0;
            eq_acc <= 1'b0;
            lt_acc <= 1'b0;
        end else if (accept) begin
            count  <= '0;
            a_q    <= a ^ msb_flip;
            b_q    <= b ^ msb_flip;
            f3_q   <= funct3;
            eq_acc <= 1'b1;
            lt_acc <= 1'b0;
        end else if (state == BUSY && !flush) begin
            // First differing slice decides the ordering; later slices are ignored.
            if (eq_acc && (a_slice != b_slice)) begin
                eq_acc <= 1'b0;
                lt_acc <= (a_slice < b_slice);
            end
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
            if (!last) count <= count + 1'b1;
        end
    end

    // Outputs are driven only from DONE, zero elsewhere
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        taken     = 1'b0;
        lt        = 1'b0;
        eq        = 1'b0;
        illegal   = 1'b0;
        if (state == DONE) begin
            eq      = eq_acc;
            lt      = lt_acc;
            illegal = (f3_q[2:1] == 2'b01);
            case (f3_q)
                3'b000:         taken = eq_acc;
                3'b001:         taken = !eq_acc;
                3'b100, 3'b110: taken = lt_acc;
                3'b101, 3'b111: taken = !lt_acc;
                default:        taken = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq (XLEN=32, CHUNK=8, latency 4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_branch_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic        lt;
    logic        eq;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    branch_cmp_seq #(.XLEN(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .lt        (lt),
        .eq        (eq),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic el, input logic ee,
                           input logic et, input logic ei);
        chk({tag, ".lt"},      lt,      el);
        chk({tag, ".eq"},      eq,      ee);
        chk({tag, ".taken"},   taken,   et);
        chk({tag, ".illegal"}, illegal, ei);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".in_ready"},  in_ready,  1'b1);
        chk({tag, ".out_valid"}, out_valid, 1'b0);
        chk_res(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full transaction: accept, 4-edge latency with scrambled operands,
    // optional back-pressure, release with in_valid held high.
    task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [2:0] f, input logic el, input logic ee,
                         input logic et, input logic ei, input int hold);
        chk({tag, ".ready"}, in_ready, 1'b1);
        a = va; b = vb; funct3 = f; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".busy_ov"}, out_valid, 1'b0);
            chk({tag, ".busy_res"}, taken | lt | eq | illegal, 1'b0);
            a = $urandom; b = $urandom; funct3 = 3'($urandom);
            @(negedge clk);
        end
        chk({tag, ".done_ov"}, out_valid, 1'b1);
        chk_res(tag, el, ee, et, ei);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_ov"}, out_valid, 1'b1);
            chk({tag, ".hold_rdy"}, in_ready, 1'b0);
            chk_res({tag, ".hold"}, el, ee, et, ei);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, ".rel_ov"}, out_valid, 1'b0);
        chk({tag, ".rel_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; funct3 = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op("blt",   32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1, 0, 1, 0, 0);
        do_op("bltu",  32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 0, 0, 0, 0);
        do_op("bgeu",  32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0, 0, 1, 0, 0);
        do_op("bne",   32'h1234_5678, 32'h1234_5678, 3'b001, 0, 1, 0, 0, 3);
        do_op("bge",   32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1, 0, 0, 0, 0);
        do_op("bge2",  32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 0, 0, 1, 0, 0);
        do_op("beq_n", 32'h1234_5679, 32'h1234_5678, 3'b000, 0, 0, 0, 0, 0);
        do_op("bltu_lo", 32'h1234_5677, 32'h1234_5678, 3'b110, 1, 0, 1, 0, 0);
        do_op("ill",   32'h0000_0005, 32'h0000_0003, 3'b011, 0, 0, 0, 1, 0);

        // Flush on the second BUSY edge
        a = 32'h0000_0005; b = 32'h0000_0003; funct3 = 3'b011; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_zero("flush");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush.no_ov", out_valid, 1'b0);
        end

        // Asynchronous reset between edges while BUSY
        a = 32'h0000_0001; b = 32'h0000_0002; funct3 = 3'b100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("post_rst");
        do_op("beq_rst", 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b000, 0, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
